// File: rtl/fact_bus_if_pkg.sv
// Shared definitions for the factorial-core bus interface: address map, FSM encoding, operand limit.
package fact_bus_if_pkg;

    localparam int unsigned A_W = 2;
    localparam int unsigned N_W = 4;

    localparam logic [A_W-1:0] ADDR_N   = 2'd0;
    localparam logic [A_W-1:0] ADDR_GO  = 2'd1;
    localparam logic [A_W-1:0] ADDR_ST  = 2'd2;
    localparam logic [A_W-1:0] ADDR_RES = 2'd3;

    // Largest operand whose factorial still fits in 32 bits
    localparam logic [N_W-1:0] N_MAX = 4'd12;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        BUSY   = 2'd2
    } state_t;

    typedef struct packed {
        logic err;
        logic done;
    } status_t;

endpackage

// File: rtl/fact_rd_mux4.sv
// Bus read path: 4:1 word mux selected by the bus address.
module fact_rd_mux4
    import fact_bus_if_pkg::*;
#(
    parameter int unsigned RES_W = 32
) (
    input  logic [A_W-1:0]   sel,
    input  logic [RES_W-1:0] d0,
    input  logic [RES_W-1:0] d1,
    input  logic [RES_W-1:0] d2,
    input  logic [RES_W-1:0] d3,
    output logic [RES_W-1:0] rd_c
);

    always_comb begin
        rd_c = d0;
        case (sel)
            ADDR_GO:  rd_c = d1;
            ADDR_ST:  rd_c = d2;
            ADDR_RES: rd_c = d3;
            default:  rd_c = d0;
        endcase
    end

endmodule

// File: rtl/fact_bus_if.sv
// Register-mapped bus front end for a factorial core: operand/launch control, status flags, result capture.
module fact_bus_if
    import fact_bus_if_pkg::*;
#(
    parameter int unsigned RES_W = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             WE,
    input  logic [A_W-1:0]   A,
    input  logic [RES_W-1:0] WD,
    output logic [RES_W-1:0] RD,
    output logic [N_W-1:0]   N_OUT,
    output logic             GO_OUT,
    input  logic             DONE_IN,
    input  logic [RES_W-1:0] RES_IN
);

    state_t           state;
    logic [N_W-1:0]   n_q;
    logic [RES_W-1:0] res_q;
    status_t          status_q;
    logic             go_q;

    logic wr_n_c;
    logic wr_go_c;
    logic busy_c;
    logic wd_unused;

    assign wr_n_c  = WE && (A == ADDR_N);
    assign wr_go_c = WE && (A == ADDR_GO) && WD[0];
    assign busy_c  = (state != IDLE);

    // Only the operand nibble and the GO bit of write data have a destination
    assign wd_unused = ^WD[RES_W-1:N_W];

    // Control FSM; GO_OUT is registered so it is high exactly while in LAUNCH
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= IDLE;
            n_q      <= '0;
            res_q    <= '0;
            status_q <= '0;
            go_q     <= 1'b0;
        end else begin
            go_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (wr_n_c) begin
                        n_q <= WD[N_W-1:0];
                    end
                    if (wr_go_c) begin
                        if (n_q <= N_MAX) begin
                            status_q <= '0;
                            go_q     <= 1'b1;
                            state    <= LAUNCH;
                        end else begin
                            status_q.err <= 1'b1;
                        end
                    end
                end
                LAUNCH: begin
                    state <= BUSY;
                end
                BUSY: begin
                    if (DONE_IN) begin
                        res_q         <= RES_IN;
                        status_q.done <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign N_OUT  = n_q;
    assign GO_OUT = go_q;

    fact_rd_mux4 #(
        .RES_W (RES_W)
    ) u_rd_mux (
        .sel  (A),
        .d0   (RES_W'(n_q)),
        .d1   (RES_W'(busy_c)),
        .d2   (RES_W'(status_q)),
        .d3   (res_q),
        .rd_c (RD)
    );

endmodule

// File: tb/tb_fact_bus_if.sv
// Self-checking bench for fact_bus_if: directed scenarios plus randomized bus/core traffic against a cycle model.
module tb_fact_bus_if;

    localparam int unsigned RES_W = 32;

    logic             CLK = 1'b0;
    logic             RST;
    logic             WE;
    logic [1:0]       A;
    logic [RES_W-1:0] WD;
    logic [RES_W-1:0] RD;
    logic [3:0]       N_OUT;
    logic             GO_OUT;
    logic             DONE_IN;
    logic [RES_W-1:0] RES_IN;

    always #5 CLK = ~CLK;

    fact_bus_if #(
        .RES_W (RES_W)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .WE      (WE),
        .A       (A),
        .WD      (WD),
        .RD      (RD),
        .N_OUT   (N_OUT),
        .GO_OUT  (GO_OUT),
        .DONE_IN (DONE_IN),
        .RES_IN  (RES_IN)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: cycles since an accepted GO (-1 = no operation in flight)
    int          m_age;
    logic [3:0]  m_n;
    logic [31:0] m_res;
    logic        m_done;
    logic        m_err;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic model_reset();
        m_age  = -1;
        m_n    = 4'd0;
        m_res  = 32'd0;
        m_done = 1'b0;
        m_err  = 1'b0;
    endtask

    function automatic logic [31:0] m_read(input int a);
        case (a)
            0:       return {28'd0, m_n};
            1:       return (m_age >= 0) ? 32'd1 : 32'd0;
            2:       return {30'd0, m_err, m_done};
            default: return m_res;
        endcase
    endfunction

    // One clock edge with the given bus/core inputs, then check the registered outputs
    task automatic step(input logic we, input logic [1:0] a, input logic [31:0] wd,
                        input logic done, input logic [31:0] res);
        WE = we; A = a; WD = wd; DONE_IN = done; RES_IN = res;
        @(posedge CLK);
        if (RST) begin
            model_reset();
        end else if (m_age < 0) begin
            if (we && a == 2'd0) m_n = wd[3:0];
            if (we && a == 2'd1 && wd[0]) begin
                if (int'(m_n) <= 12) begin
                    m_done = 1'b0;
                    m_err  = 1'b0;
                    m_age  = 0;
                end else begin
                    m_err = 1'b1;
                end
            end
        end else if (m_age == 0) begin
            m_age = 1;
        end else if (done) begin
            m_res  = res;
            m_done = 1'b1;
            m_age  = -1;
        end
        #1;
        WE = 1'b0; DONE_IN = 1'b0;
        chk("go_out", {31'd0, GO_OUT}, 32'(m_age == 0));
        chk("n_out", {28'd0, N_OUT}, {28'd0, m_n});
    endtask

    task automatic rd_exp(input string tag, input int a, input logic [31:0] exp);
        A = 2'(a);
        #1;
        chk(tag, RD, exp);
    endtask

    task automatic rd_all(input string tag);
        for (int a = 0; a < 4; a++) begin
            A = 2'(a);
            #1;
            chk($sformatf("%s_rd%0d", tag, a), RD, m_read(a));
        end
    endtask

    initial begin
        RST = 1'b1; WE = 1'b0; A = 2'd0; WD = '0; DONE_IN = 1'b0; RES_IN = '0;
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        chk("rst_go", {31'd0, GO_OUT}, 32'd0);
        rd_all("rst");

        // N=5 launch, core answers 120
        step(1'b1, 2'd0, 32'd5, 1'b0, 32'd0);
        step(1'b1, 2'd1, 32'd1, 1'b0, 32'd0);
        chk("n5_go", {31'd0, GO_OUT}, 32'd1);
        rd_exp("n5_busy_launch", 1, 32'd1);
        step(1'b0, 2'd0, 32'd0, 1'b0, 32'd0);
        rd_exp("n5_busy", 1, 32'd1);
        step(1'b0, 2'd0, 32'd0, 1'b1, 32'd120);
        rd_exp("n5_status", 2, 32'd1);
        rd_exp("n5_result", 3, 32'd120);
        rd_exp("n5_idle", 1, 32'd0);

        // N=13 rejected, then N=3 clears flags
        step(1'b1, 2'd0, 32'd13, 1'b0, 32'd0);
        step(1'b1, 2'd1, 32'd1, 1'b0, 32'd0);
        chk("n13_nogo", {31'd0, GO_OUT}, 32'd0);
        rd_exp("n13_status", 2, 32'd3);
        rd_exp("n13_idle", 1, 32'd0);
        step(1'b1, 2'd0, 32'd3, 1'b0, 32'd0);
        step(1'b1, 2'd1, 32'd1, 1'b0, 32'd0);
        rd_exp("n3_status_clr", 2, 32'd0);
        step(1'b0, 2'd0, 32'd0, 1'b0, 32'd0);
        step(1'b0, 2'd0, 32'd0, 1'b1, 32'd6);
        rd_exp("n3_result", 3, 32'd6);
        rd_exp("n3_status", 2, 32'd1);

        // Writes while busy are dropped; DONE in idle ignored
        step(1'b1, 2'd0, 32'd2, 1'b0, 32'd0);
        step(1'b1, 2'd1, 32'd1, 1'b0, 32'd0);
        step(1'b1, 2'd0, 32'd7, 1'b0, 32'd0);
        step(1'b1, 2'd1, 32'd1, 1'b0, 32'd0);
        rd_exp("busy_n_keep", 0, 32'd2);
        step(1'b1, 2'd0, 32'd7, 1'b0, 32'd0);
        step(1'b0, 2'd0, 32'd0, 1'b1, 32'd2);
        step(1'b0, 2'd0, 32'd0, 1'b1, 32'd99);
        rd_exp("busy_result", 3, 32'd2);
        rd_exp("busy_n_final", 0, 32'd2);

        // DONE coincident with GO write in BUSY
        step(1'b1, 2'd0, 32'd6, 1'b0, 32'd0);
        step(1'b1, 2'd1, 32'd1, 1'b0, 32'd0);
        step(1'b0, 2'd0, 32'd0, 1'b0, 32'd0);
        step(1'b1, 2'd1, 32'd1, 1'b1, 32'd720);
        step(1'b0, 2'd0, 32'd0, 1'b0, 32'd0);
        chk("coinc_nolaunch", {31'd0, GO_OUT}, 32'd0);
        rd_exp("coinc_result", 3, 32'd720);
        rd_exp("coinc_status", 2, 32'd1);
        rd_exp("coinc_idle", 1, 32'd0);

        // Reset mid-operation, late DONE ignored
        step(1'b1, 2'd0, 32'd4, 1'b0, 32'd0);
        step(1'b1, 2'd1, 32'd1, 1'b0, 32'd0);
        step(1'b0, 2'd0, 32'd0, 1'b0, 32'd0);
        RST = 1'b1;
        #1;
        model_reset();
        chk("rst_async_n", {28'd0, N_OUT}, 32'd0);
        rd_exp("rst_async_busy", 1, 32'd0);
        rd_exp("rst_async_res", 3, 32'd0);
        step(1'b0, 2'd0, 32'd0, 1'b0, 32'd0);
        RST = 1'b0;
        step(1'b0, 2'd0, 32'd0, 1'b1, 32'd24);
        rd_exp("late_done_res", 3, 32'd0);
        rd_exp("late_done_st", 2, 32'd0);

        // N=0 launches normally
        step(1'b1, 2'd0, 32'd0, 1'b0, 32'd0);
        step(1'b1, 2'd1, 32'd1, 1'b0, 32'd0);
        chk("n0_go", {31'd0, GO_OUT}, 32'd1);
        chk("n0_nout", {28'd0, N_OUT}, 32'd0);
        step(1'b0, 2'd0, 32'd0, 1'b0, 32'd0);
        step(1'b0, 2'd0, 32'd0, 1'b1, 32'd1);
        rd_exp("n0_result", 3, 32'd1);

        // Randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            logic        we;
            logic [1:0]  a;
            logic [31:0] wd;
            logic        dn;
            we = 1'($urandom_range(0, 1));
            a  = 2'($urandom_range(0, 3));
            wd = $urandom;
            dn = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 199) == 0) RST = 1'b1;
            step(we, a, wd, dn, $urandom);
            RST = 1'b0;
            rd_all("rnd");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
